// File: rtl/imem_pkg.sv
// Shared types and constants for the pipelined SimpleARM instruction memory.
package imem_pkg;

    // Default instruction word width.
    localparam int unsigned DATA_W_DEF = 32;

    // ARM encodings: mov r0,r0 (returned on bad fetches) and "b ." (branch to self).
    localparam logic [31:0] ARM_NOP    = 32'hE1A00000;
    localparam logic [31:0] ARM_B_SELF = 32'hEAFFFFFE;

    // Width of the word index carried in each pipeline stage (covers DEPTH up to 64K).
    localparam int unsigned IDX_W = 16;

    // One pipeline stage: occupancy, array word index and error flag.
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic             err;
    } imem_stage_t;

    // True when a zero-extended word index addresses a real array entry.
    function automatic logic idx_in_range(input logic [63:0] widx, input int unsigned depth);
        return widx < 64'(depth);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous read port with enable, one write port.
// No reset on the storage or the read register so the tools can map it to block RAM.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned DATA_W = DATA_W_DEF,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port and registered read; the read register holds when re_i is low.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_pipelined.sv
// Pipelined instruction memory: fetch request/response handshake with configurable
// read latency, response backpressure, flush for branch redirection and a program-load
// write port. Stage 1 is the synchronous array read; later stages only carry data.
module imem_pipelined
    import imem_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = DATA_W_DEF,
    parameter int unsigned       DEPTH     = 128,
    parameter int unsigned       LATENCY   = 1,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(ARM_NOP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              flush,
    input  logic              prog_en,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Handshake control.
    logic stall;
    logic accept;

    // Request decode.
    logic [ADDR_W-3:0] req_widx;
    logic [AW-1:0]     req_aidx;
    logic              req_misaligned;
    logic              req_oor;
    logic              req_err;

    // Program port decode.
    logic [AW-1:0]     prog_aidx;
    logic              prog_we;

    // Array read data (valid in the cycle after an accepted, error-free fetch).
    logic [DATA_W-1:0] rdata;

    // Per-stage views, indexed 0 .. LATENCY-1 (stage 1 is index 0).
    imem_stage_t       stage      [LATENCY];
    logic [DATA_W-1:0] stage_data [LATENCY];

    assign req_widx       = req_addr[ADDR_W-1:2];
    assign req_aidx       = req_addr[2 +: AW];
    assign req_misaligned = |req_addr[1:0];
    assign req_oor        = !idx_in_range(64'(req_widx), DEPTH);
    assign req_err        = req_misaligned | req_oor;

    assign prog_aidx = prog_addr[2 +: AW];
    assign prog_we   = prog_en & idx_in_range(64'(prog_addr[ADDR_W-1:2]), DEPTH);

    // The last stage drives the response; data is forced to zero when nothing is valid.
    assign rsp_valid = stage[LATENCY-1].valid;
    assign rsp_err   = stage[LATENCY-1].valid & stage[LATENCY-1].err;
    assign rsp_data  = rsp_valid ? stage_data[LATENCY-1] : '0;

    assign stall     = rsp_valid & ~rsp_ready;
    assign req_ready = ~stall & ~prog_en;
    assign accept    = req_valid & req_ready;

    // Bad fetches never touch the array, so an out-of-range address cannot alias.
    imem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i   (clk),
        .re_i    (accept & ~req_err),
        .raddr_i (req_aidx),
        .rdata_o (rdata),
        .we_i    (prog_we),
        .waddr_i (prog_aidx),
        .wdata_i (prog_data)
    );

    for (genvar g = 0; g < LATENCY; g++) begin : gen_stage
        imem_stage_t st_q;
        imem_stage_t st_d;

        if (g == 0) begin : gen_head
            // Head stage: load on accept, hold on stall, otherwise drain to empty.
            // A request accepted alongside a flush is the redirect target and is kept.
            always_comb begin
                st_d = st_q;
                if (accept) begin
                    st_d.valid = 1'b1;
                    st_d.idx   = IDX_W'(req_aidx);
                    st_d.err   = req_err;
                end else if (flush || !stall) begin
                    st_d = '0;
                end
            end

            // Errored fetches substitute the fill word for the (unread) array output.
            assign stage_data[g] = st_q.err ? FILL_WORD : rdata;
        end else begin : gen_tail
            logic [DATA_W-1:0] data_q;
            logic [DATA_W-1:0] data_d;

            // Tail stage: shift from the previous stage unless stalled; flush always empties.
            always_comb begin
                st_d   = st_q;
                data_d = data_q;
                if (!stall) begin
                    st_d   = stage[g-1];
                    data_d = stage_data[g-1];
                end
                if (flush) begin
                    st_d = '0;
                end
            end

            // Carried instruction word for this stage.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end

            assign stage_data[g] = data_q;
        end

        // Stage control register; reset empties the pipeline.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st_q <= '0;
            end else begin
                st_q <= st_d;
            end
        end

        assign stage[g] = st_q;
    end

    // The last stage's index and the byte-offset bits of prog_addr are informational only.
    logic unused_bits;
    assign unused_bits = ^{stage[LATENCY-1].idx, prog_addr[1:0]};

endmodule

// File: tb/tb_imem_pipelined.sv
// Directed bench for imem_pipelined: three instances (LATENCY 1, 2, 3) share all inputs;
// each scenario checks the instance whose latency it is about.
module tb_imem_pipelined;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        flush;
    logic        prog_en;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;

    // Index 0: LATENCY=1, 1: LATENCY=2, 2: LATENCY=3.
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_err;
    logic [31:0] rsp_data [3];

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP    = 32'hE1A00000;
    localparam logic [31:0] B_SELF = 32'hEAFFFFFE;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    imem_pipelined #(.LATENCY(1)) u_l1 (
        .clk (clk), .reset (reset),
        .req_valid (req_valid), .req_ready (req_ready[0]), .req_addr (req_addr),
        .rsp_valid (rsp_valid[0]), .rsp_ready (rsp_ready), .rsp_data (rsp_data[0]),
        .rsp_err (rsp_err[0]), .flush (flush),
        .prog_en (prog_en), .prog_addr (prog_addr), .prog_data (prog_data)
    );

    imem_pipelined #(.LATENCY(2)) u_l2 (
        .clk (clk), .reset (reset),
        .req_valid (req_valid), .req_ready (req_ready[1]), .req_addr (req_addr),
        .rsp_valid (rsp_valid[1]), .rsp_ready (rsp_ready), .rsp_data (rsp_data[1]),
        .rsp_err (rsp_err[1]), .flush (flush),
        .prog_en (prog_en), .prog_addr (prog_addr), .prog_data (prog_data)
    );

    imem_pipelined #(.LATENCY(3)) u_l3 (
        .clk (clk), .reset (reset),
        .req_valid (req_valid), .req_ready (req_ready[2]), .req_addr (req_addr),
        .rsp_valid (rsp_valid[2]), .rsp_ready (rsp_ready), .rsp_data (rsp_data[2]),
        .rsp_err (rsp_err[2]), .flush (flush),
        .prog_en (prog_en), .prog_addr (prog_addr), .prog_data (prog_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input logic [31:0] a, input logic [31:0] d);
        prog_en   = 1'b1;
        prog_addr = a;
        prog_data = d;
        next_cycle();
        prog_en   = 1'b0;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        repeat (5) next_cycle();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        flush     = 1'b0;
        prog_en   = 1'b0;
        prog_addr = '0;
        prog_data = '0;

        vecs[0]  = '{32'h0000_0000, 32'hE3A000AA, 1'b0};
        vecs[1]  = '{32'h0000_0004, 32'hE3A000AB, 1'b0};
        vecs[2]  = '{32'h0000_0008, 32'hE3A000AC, 1'b0};
        vecs[3]  = '{32'h0000_000C, 32'hE3A000AD, 1'b0};
        vecs[4]  = '{32'h0000_0010, 32'hE3A000AE, 1'b0};
        vecs[5]  = '{32'h0000_0014, 32'hE3A000AF, 1'b0};
        vecs[6]  = '{32'h0000_0018, 32'hE3A000B0, 1'b0};
        vecs[7]  = '{32'h0000_001C, 32'hE3A000B1, 1'b0};
        vecs[8]  = '{32'h0000_0002, NOP,          1'b1};
        vecs[9]  = '{32'h0000_0200, NOP,          1'b1};
        vecs[10] = '{32'h0000_01FC, 32'h12345678, 1'b0};
        vecs[11] = '{32'h0000_0203, NOP,          1'b1};
        vecs[12] = '{32'h0000_003C, 32'hE3A000B9, 1'b0};
        vecs[13] = '{32'hFFFF_FFFC, NOP,          1'b1};
        vecs[14] = '{32'h0000_0001, NOP,          1'b1};

        // Reset state.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset rsp_valid[%0d]", i), rsp_valid[i], 1'b0);
            chk($sformatf("reset rsp_data[%0d]", i), rsp_data[i], 32'h0);
            chk($sformatf("reset rsp_err[%0d]", i), rsp_err[i], 1'b0);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("post-reset req_ready[%0d]", i), req_ready[i], 1'b1);
        end
        next_cycle();

        // Program load: words 0..15, word 127 via an unaligned address, and an
        // out-of-range write that would alias word 0 if it were not ignored.
        for (int i = 0; i < 16; i++) begin
            prog_write(32'(i * 4), 32'hE3A000AA + 32'(i));
        end
        prog_write(32'h0000_01FF, 32'h12345678);
        prog_write(32'h0000_0200, 32'hDEADBEEF);

        // Back-to-back table fetches on LATENCY=1: one response per cycle, in order.
        for (int k = 0; k <= NV; k++) begin
            if (k < NV) begin
                req_valid = 1'b1;
                req_addr  = vecs[k].addr;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            if (k < NV) chk($sformatf("tbl%0d req_ready", k), req_ready[0], 1'b1);
            if (k == 0) begin
                chk("tbl idle rsp_valid", rsp_valid[0], 1'b0);
            end else begin
                chk($sformatf("tbl%0d rsp_valid", k - 1), rsp_valid[0], 1'b1);
                chk($sformatf("tbl%0d rsp_data", k - 1), rsp_data[0], vecs[k-1].data);
                chk($sformatf("tbl%0d rsp_err", k - 1), rsp_err[0], vecs[k-1].err);
            end
            next_cycle();
        end
        drain();

        // LATENCY=3: exact latency, then a 5-cycle stall with a second fetch queued behind.
        req_valid = 1'b1;
        req_addr  = 32'h10;
        @(negedge clk);
        chk("lat3 req_ready", req_ready[2], 1'b1);
        next_cycle();
        req_addr = 32'h14;
        @(negedge clk);
        chk("lat3 +1 rsp_valid", rsp_valid[2], 1'b0);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        chk("lat3 +2 rsp_valid", rsp_valid[2], 1'b0);
        next_cycle();
        for (int j = 0; j < 5; j++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            chk($sformatf("stall%0d rsp_valid", j), rsp_valid[2], 1'b1);
            chk($sformatf("stall%0d rsp_data", j), rsp_data[2], 32'hE3A000AE);
            chk($sformatf("stall%0d rsp_err", j), rsp_err[2], 1'b0);
            chk($sformatf("stall%0d req_ready", j), req_ready[2], 1'b0);
            next_cycle();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("unstall first valid", rsp_valid[2], 1'b1);
        chk("unstall first data", rsp_data[2], 32'hE3A000AE);
        next_cycle();
        @(negedge clk);
        chk("unstall second valid", rsp_valid[2], 1'b1);
        chk("unstall second data", rsp_data[2], 32'hE3A000AF);
        next_cycle();
        @(negedge clk);
        chk("unstall empty", rsp_valid[2], 1'b0);
        next_cycle();
        drain();

        // Flush with a redirect request; the consumer ignores whatever is shown in the flush cycle.
        req_valid = 1'b1;
        req_addr  = 32'h0;
        next_cycle();
        req_addr = 32'h4;
        next_cycle();
        req_addr = 32'h20;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush req_ready l2", req_ready[1], 1'b1);
        next_cycle();
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        chk("flush+1 l2 rsp_valid", rsp_valid[1], 1'b0);
        chk("flush+1 l1 rsp_valid", rsp_valid[0], 1'b1);
        chk("flush+1 l1 rsp_data", rsp_data[0], 32'hE3A000B2);
        chk("flush+1 l3 rsp_valid", rsp_valid[2], 1'b0);
        next_cycle();
        @(negedge clk);
        chk("flush+2 l2 rsp_valid", rsp_valid[1], 1'b1);
        chk("flush+2 l2 rsp_data", rsp_data[1], 32'hE3A000B2);
        chk("flush+2 l3 rsp_valid", rsp_valid[2], 1'b0);
        next_cycle();
        @(negedge clk);
        chk("flush+3 l2 rsp_valid", rsp_valid[1], 1'b0);
        chk("flush+3 l3 rsp_valid", rsp_valid[2], 1'b1);
        chk("flush+3 l3 rsp_data", rsp_data[2], 32'hE3A000B2);
        next_cycle();
        @(negedge clk);
        chk("flush+4 l3 rsp_valid", rsp_valid[2], 1'b0);
        next_cycle();
        drain();

        // Flush during a stall drops the pending response.
        req_valid = 1'b1;
        req_addr  = 32'h0;
        next_cycle();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        chk("flush-stall pending valid", rsp_valid[0], 1'b1);
        chk("flush-stall req_ready", req_ready[0], 1'b0);
        next_cycle();
        flush     = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("flush-stall dropped", rsp_valid[0], 1'b0);
        next_cycle();
        drain();

        // Program write while a fetch of the same word is in flight; a colliding request waits.
        req_valid = 1'b1;
        req_addr  = 32'h14;
        next_cycle();
        prog_en   = 1'b1;
        prog_addr = 32'h14;
        prog_data = B_SELF;
        @(negedge clk);
        chk("wr req_ready blocked", req_ready[0], 1'b0);
        chk("wr inflight l1 valid", rsp_valid[0], 1'b1);
        chk("wr inflight l1 data", rsp_data[0], 32'hE3A000AF);
        next_cycle();
        prog_en = 1'b0;
        @(negedge clk);
        chk("wr+1 req_ready", req_ready[0], 1'b1);
        chk("wr+1 l1 no rsp", rsp_valid[0], 1'b0);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        chk("wr+2 l1 valid", rsp_valid[0], 1'b1);
        chk("wr+2 l1 new data", rsp_data[0], B_SELF);
        chk("wr+2 l3 valid", rsp_valid[2], 1'b1);
        chk("wr+2 l3 old data", rsp_data[2], 32'hE3A000AF);
        next_cycle();
        @(negedge clk);
        chk("wr+3 l3 gap", rsp_valid[2], 1'b0);
        next_cycle();
        @(negedge clk);
        chk("wr+4 l3 valid", rsp_valid[2], 1'b1);
        chk("wr+4 l3 new data", rsp_data[2], B_SELF);
        next_cycle();
        drain();

        // Asynchronous reset with fetches in flight; array contents survive.
        req_valid = 1'b1;
        req_addr  = 32'h0;
        next_cycle();
        req_addr = 32'h4;
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset l2 valid", rsp_valid[1], 1'b1);
        chk("pre-reset l2 data", rsp_data[1], 32'hE3A000AA);
        chk("pre-reset l1 valid", rsp_valid[0], 1'b1);
        chk("pre-reset l1 data", rsp_data[0], 32'hE3A000AB);
        #1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("async reset rsp_valid[%0d]", i), rsp_valid[i], 1'b0);
            chk($sformatf("async reset rsp_data[%0d]", i), rsp_data[i], 32'h0);
        end
        next_cycle();
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("post-reset%0d l3 no rsp", j), rsp_valid[2], 1'b0);
            chk($sformatf("post-reset%0d l2 req_ready", j), req_ready[1], 1'b1);
            next_cycle();
        end
        req_valid = 1'b1;
        req_addr  = 32'h1C;
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        chk("persist l1 valid", rsp_valid[0], 1'b1);
        chk("persist l1 data", rsp_data[0], 32'hE3A000B1);
        next_cycle();
        @(negedge clk);
        chk("persist l2 valid", rsp_valid[1], 1'b1);
        chk("persist l2 data", rsp_data[1], 32'hE3A000B1);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
